// File: rtl/tdp_ram_be.sv
// rtl/tdp_ram_be.sv - true dual-port RAM with byte enables, registered reads and post-reset clear sweep
module tdp_ram_be #(
  parameter int D_WIDTH      = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int OUT_REG      = 0,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  coll,
  input  logic                  en_a,
  input  logic [D_WIDTH/8-1:0]  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [D_WIDTH-1:0]    din_a,
  output logic [D_WIDTH-1:0]    dout_a,
  output logic                  vld_a,
  input  logic                  en_b,
  input  logic [D_WIDTH/8-1:0]  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [D_WIDTH-1:0]    din_b,
  output logic [D_WIDTH-1:0]    dout_b,
  output logic                  vld_b
);
  localparam int NB    = D_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_IDLE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    clr_we;
  logic [NB-1:0][7:0]      mem_q [DEPTH];

  logic                    acc_a, acc_b;
  logic [NB-1:0]           wa, wb;
  logic [D_WIDTH-1:0]      rdata_a, rdata_b;
  logic [D_WIDTH-1:0]      dout1_a_q, dout1_a_d, dout1_b_q, dout1_b_d;
  logic                    vld1_a_q, vld1_a_d, vld1_b_q, vld1_b_d;
  logic                    coll_q, coll_d;

  // The first idle cycle after rst falls already clears word 0, so the sweep spans DEPTH cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_RESET: begin
        if (CLEAR_ON_RST != 0) begin
          clr_we  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = rst | (state_q != S_IDLE);
  assign acc_a = en_a & ~busy;
  assign acc_b = en_b & ~busy;
  assign wa    = acc_a ? we_a : '0;
  assign wb    = acc_b ? we_b : '0;

  // Overlapping bytes at the same address resolve to port A.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) mem_q[cnt_q] <= '0;
      for (int i = 0; i < NB; i++) begin
        if (wa[i]) mem_q[addr_a][i] <= din_a[8*i +: 8];
        if (wb[i] && !(wa[i] && (addr_a == addr_b))) mem_q[addr_b][i] <= din_b[8*i +: 8];
      end
    end
  end

  // Write-first only merges the port's own write; the other port's write is never visible.
  always_comb begin
    rdata_a = mem_q[addr_a];
    rdata_b = mem_q[addr_b];
    if (RDW_MODE != 0) begin
      for (int i = 0; i < NB; i++) begin
        if (wa[i]) rdata_a[8*i +: 8] = din_a[8*i +: 8];
        if (wb[i]) rdata_b[8*i +: 8] = din_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    dout1_a_d = acc_a ? rdata_a : dout1_a_q;
    dout1_b_d = acc_b ? rdata_b : dout1_b_q;
    vld1_a_d  = acc_a;
    vld1_b_d  = acc_b;
    coll_d    = acc_a & acc_b & (addr_a == addr_b) & ((|we_a) | (|we_b));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout1_a_q <= '0;
      dout1_b_q <= '0;
      vld1_a_q  <= 1'b0;
      vld1_b_q  <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      dout1_a_q <= dout1_a_d;
      dout1_b_q <= dout1_b_d;
      vld1_a_q  <= vld1_a_d;
      vld1_b_q  <= vld1_b_d;
      coll_q    <= coll_d;
    end
  end

  assign coll = coll_q;

  if (OUT_REG != 0) begin : g_oreg
    logic [D_WIDTH-1:0] dout2_a_q, dout2_a_d, dout2_b_q, dout2_b_d;
    logic               vld2_a_q, vld2_b_q;

    always_comb begin
      dout2_a_d = vld1_a_q ? dout1_a_q : dout2_a_q;
      dout2_b_d = vld1_b_q ? dout1_b_q : dout2_b_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout2_a_q <= '0;
        dout2_b_q <= '0;
        vld2_a_q  <= 1'b0;
        vld2_b_q  <= 1'b0;
      end else begin
        dout2_a_q <= dout2_a_d;
        dout2_b_q <= dout2_b_d;
        vld2_a_q  <= vld1_a_q;
        vld2_b_q  <= vld1_b_q;
      end
    end

    assign dout_a = dout2_a_q;
    assign dout_b = dout2_b_q;
    assign vld_a  = vld2_a_q;
    assign vld_b  = vld2_b_q;
  end else begin : g_noreg
    assign dout_a = dout1_a_q;
    assign dout_b = dout1_b_q;
    assign vld_a  = vld1_a_q;
    assign vld_b  = vld1_b_q;
  end

endmodule

// File: tb/tb_tdp_ram_be.sv
// tb/tb_tdp_ram_be.sv - directed vector bench for tdp_ram_be (read-first, write-first and output-register variants)
module tb_tdp_ram_be;
  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b, addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic        busy, coll, vld_a, vld_b;
  logic [31:0] dout_a, dout_b;
  logic        w_busy, w_coll, w_vld_a, w_vld_b;
  logic [31:0] w_dout_a, w_dout_b;
  logic        o_busy, o_coll, o_vld_a, o_vld_b;
  logic [31:0] o_dout_a, o_dout_b;

  always #5 clk = ~clk;

  tdp_ram_be #(.D_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RST(1)) u_dut (
    .clk(clk), .rst(rst), .busy(busy), .coll(coll),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a), .vld_a(vld_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b), .vld_b(vld_b));

  tdp_ram_be #(.D_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .RDW_MODE(1), .CLEAR_ON_RST(1)) u_wf (
    .clk(clk), .rst(rst), .busy(w_busy), .coll(w_coll),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(w_dout_a), .vld_a(w_vld_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(w_dout_b), .vld_b(w_vld_b));

  tdp_ram_be #(.D_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .RDW_MODE(0), .CLEAR_ON_RST(1)) u_or (
    .clk(clk), .rst(rst), .busy(o_busy), .coll(o_coll),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(o_dout_a), .vld_a(o_vld_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(o_dout_b), .vld_b(o_vld_b));

  typedef struct {
    logic        en_a;
    logic [3:0]  we_a;
    logic [3:0]  addr_a;
    logic [31:0] din_a;
    logic        en_b;
    logic [3:0]  we_b;
    logic [3:0]  addr_b;
    logic [31:0] din_b;
    logic [31:0] exp_a;
    logic [31:0] exp_wa;
    logic [31:0] exp_b;
    logic [31:0] exp_wb;
    logic        exp_coll;
  } vec_t;

  vec_t        vt [15];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_a, last_b;
  logic [31:0] words [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string name, input int exp_n, input logic drive_a);
    int n;
    n = 0;
    while (busy && n < 40) begin
      if (drive_a) chk({name, "_vld_a_busy"}, {31'b0, vld_a}, 32'h0);
      n++;
      tick();
    end
    if (drive_a) en_a = 1'b0;
    chk({name, "_busy_cycles"}, n, exp_n);
  endtask

  initial begin
    vt[0]  = '{1'b1, 4'hF, 4'd3,  32'hAABBCCDD, 1'b0, 4'h0, 4'd0,  32'h0,
               32'h0, 32'hAABBCCDD, 32'h0, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 4'h5, 4'd3,  32'h11223344, 1'b0, 4'h0, 4'd0,  32'h0,
               32'hAABBCCDD, 32'hAA22CC44, 32'h0, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 4'h0, 4'd0,  32'h0, 1'b1, 4'h0, 4'd3, 32'h0,
               32'h0, 32'h0, 32'hAA22CC44, 32'hAA22CC44, 1'b0};
    vt[3]  = '{1'b1, 4'hF, 4'd5,  32'h00000001, 1'b0, 4'h0, 4'd0, 32'h0,
               32'h0, 32'h00000001, 32'h0, 32'h0, 1'b0};
    vt[4]  = '{1'b1, 4'hF, 4'd5,  32'h00000002, 1'b0, 4'h0, 4'd0, 32'h0,
               32'h00000001, 32'h00000002, 32'h0, 32'h0, 1'b0};
    vt[5]  = '{1'b1, 4'h3, 4'd7,  32'h0000FFFF, 1'b1, 4'hF, 4'd7, 32'hFFFF0000,
               32'h0, 32'h0000FFFF, 32'h0, 32'hFFFF0000, 1'b1};
    vt[6]  = '{1'b1, 4'h0, 4'd7,  32'h0, 1'b1, 4'h0, 4'd7, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vt[7]  = '{1'b1, 4'hC, 4'd9,  32'h11111111, 1'b1, 4'h6, 4'd9, 32'h22222222,
               32'h0, 32'h11110000, 32'h0, 32'h00222200, 1'b1};
    vt[8]  = '{1'b0, 4'h0, 4'd0,  32'h0, 1'b1, 4'h0, 4'd9, 32'h0,
               32'h0, 32'h0, 32'h11112200, 32'h11112200, 1'b0};
    vt[9]  = '{1'b1, 4'hF, 4'd10, 32'hDEADBEEF, 1'b1, 4'h0, 4'd10, 32'h0,
               32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1};
    vt[10] = '{1'b1, 4'h0, 4'd10, 32'h0, 1'b1, 4'h0, 4'd10, 32'h0,
               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vt[11] = '{1'b1, 4'hF, 4'd1,  32'h01020304, 1'b1, 4'hF, 4'd2, 32'h05060708,
               32'h0, 32'h01020304, 32'h0, 32'h05060708, 1'b0};
    vt[12] = '{1'b1, 4'h0, 4'd2,  32'h0, 1'b1, 4'h0, 4'd1, 32'h0,
               32'h05060708, 32'h05060708, 32'h01020304, 32'h01020304, 1'b0};
    vt[13] = '{1'b0, 4'hF, 4'd1,  32'hFFFFFFFF, 1'b0, 4'hF, 4'd2, 32'hFFFFFFFF,
               32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    vt[14] = '{1'b1, 4'h0, 4'd1,  32'h0, 1'b1, 4'h0, 4'd2, 32'h0,
               32'h01020304, 32'h01020304, 32'h05060708, 32'h05060708, 1'b0};
    words[0] = 32'h0; words[1] = 32'h01020304; words[2] = 32'h05060708; words[3] = 32'hAA22CC44;

    // Reset state and clear sweep
    idle_in();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_dout_a", dout_a, 32'h0);
    chk("rst_vld_a", {31'b0, vld_a}, 32'h0);
    chk("rst_vld_b", {31'b0, vld_b}, 32'h0);
    chk("rst_coll", {31'b0, coll}, 32'h0);
    rst = 1'b0;
    count_busy("clear", 16, 1'b0);

    for (int i = 0; i < 16; i++) begin
      en_a = 1'b1; addr_a = i[3:0];
      tick();
      chk($sformatf("clr_word%0d", i), dout_a, 32'h0);
      chk($sformatf("clr_vld%0d", i), {31'b0, vld_a}, 32'h1);
    end
    idle_in();
    tick();
    last_a = 32'h0;
    last_b = 32'h0;

    for (int v = 0; v < 15; v++) begin
      en_a = vt[v].en_a; we_a = vt[v].we_a; addr_a = vt[v].addr_a; din_a = vt[v].din_a;
      en_b = vt[v].en_b; we_b = vt[v].we_b; addr_b = vt[v].addr_b; din_b = vt[v].din_b;
      tick();
      chk($sformatf("v%0d_vld_a", v), {31'b0, vld_a}, {31'b0, vt[v].en_a});
      chk($sformatf("v%0d_vld_b", v), {31'b0, vld_b}, {31'b0, vt[v].en_b});
      chk($sformatf("v%0d_coll", v), {31'b0, coll}, {31'b0, vt[v].exp_coll});
      if (vt[v].en_a) begin
        chk($sformatf("v%0d_dout_a", v), dout_a, vt[v].exp_a);
        chk($sformatf("v%0d_wf_dout_a", v), w_dout_a, vt[v].exp_wa);
        last_a = vt[v].exp_a;
      end else begin
        chk($sformatf("v%0d_hold_a", v), dout_a, last_a);
      end
      if (vt[v].en_b) begin
        chk($sformatf("v%0d_dout_b", v), dout_b, vt[v].exp_b);
        chk($sformatf("v%0d_wf_dout_b", v), w_dout_b, vt[v].exp_wb);
        last_b = vt[v].exp_b;
      end else begin
        chk($sformatf("v%0d_hold_b", v), dout_b, last_b);
      end
    end
    idle_in();
    tick();
    tick();

    // Output-register latency: reads issued at four consecutive edges
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        en_a = 1'b1; addr_a = c[3:0];
      end else begin
        en_a = 1'b0;
      end
      tick();
      chk($sformatf("oreg_vld_c%0d", c), {31'b0, o_vld_a}, (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
      if (c >= 1 && c <= 4) chk($sformatf("oreg_data_c%0d", c), o_dout_a, words[c-1]);
    end
    idle_in();
    tick();

    // Mid-sweep reset with write attempts to word 0 during busy
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_a = 1'b1; we_a = 4'hF; addr_a = 4'd0; din_a = 32'h12345678;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("sweep1_busy%0d", k), {31'b0, busy}, 32'h1);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("midrst_busy", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    count_busy("sweep2", 16, 1'b1);
    idle_in();
    en_a = 1'b1; addr_a = 4'd0;
    en_b = 1'b1; addr_b = 4'd3;
    tick();
    chk("busy_write_ignored", dout_a, 32'h0);
    chk("sweep2_word3", dout_b, 32'h0);
    idle_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
